// File: rtl/uart_apb_ctrl_pkg.sv
// uart_apb_ctrl_pkg: FSM states, default uart_mini register offsets and FSTAT bit positions.
// The RXR state only exists when UART_APB_CTRL_RX_EN is defined.
package uart_apb_ctrl_pkg;
   localparam logic [15:0] DEF_ADDR_CSR    = 16'h0;
   localparam logic [15:0] DEF_ADDR_DIV    = 16'h4;
   localparam logic [15:0] DEF_ADDR_FSTAT  = 16'h8;
   localparam logic [15:0] DEF_ADDR_TX     = 16'hc;
   localparam logic [15:0] DEF_ADDR_RX     = 16'h10;
   localparam logic [31:0] DEF_CSR_ON      = 32'h1;
   localparam int          DEF_TXFULL_BIT  = 8;
   localparam int          DEF_RXEMPTY_BIT = 25;
   typedef enum logic [2:0] {
      IDLE, WDIV, WCSR, POLL, TXW, STOP
`ifdef UART_APB_CTRL_RX_EN
      , RXR
`endif
   } state_t;
endpackage

// File: rtl/uart_apb_ctrl_xfer.sv
// uart_apb_ctrl_xfer: single APB master transfer engine (SETUP one cycle, ACCESS until pready).
// Ports: clk/rst_n; req/addr/write/wdata request (sampled whenever the engine is free,
// including the completion cycle, so transfers run back to back); done/rdata/slverr
// completion; apbm_* APB master interface.
module uart_apb_ctrl_xfer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic        slverr,
   output logic        apbm_psel,
   output logic        apbm_penable,
   output logic        apbm_pwrite,
   output logic [15:0] apbm_paddr,
   output logic [31:0] apbm_pwdata,
   input  logic [31:0] apbm_prdata,
   input  logic        apbm_pready,
   input  logic        apbm_pslverr
);
   assign done   = apbm_psel && apbm_penable && apbm_pready;
   assign rdata  = apbm_prdata;
   assign slverr = done && apbm_pslverr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apbm_psel    <= 1'b0;
         apbm_penable <= 1'b0;
         apbm_pwrite  <= 1'b0;
         apbm_paddr   <= 16'h0;
         apbm_pwdata  <= 32'h0;
      end else if (!apbm_psel || done) begin
         apbm_psel    <= req;
         apbm_penable <= 1'b0;
         if (req) begin
            apbm_paddr  <= addr;
            apbm_pwrite <= write;
            apbm_pwdata <= wdata;
         end
      end else begin
         apbm_penable <= 1'b1;
      end
   end
endmodule

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB master that configures uart_mini and bridges its TX/RX FIFOs to byte streams.
// Ports: clk, rst_n; cfg_start/cfg_stop/cfg_div control; running/err status;
// tx_valid/tx_ready/tx_data TX stream in; rx_valid/rx_ready/rx_data RX stream out;
// apbm_* APB master. Define UART_APB_CTRL_RX_EN to enable the RX path; otherwise
// rx_valid/rx_data are tied low and received bytes stay in the UART FIFO.
module uart_apb_ctrl
   import uart_apb_ctrl_pkg::*;
#(
   parameter logic [15:0] ADDR_CSR    = DEF_ADDR_CSR,
   parameter logic [15:0] ADDR_DIV    = DEF_ADDR_DIV,
   parameter logic [15:0] ADDR_FSTAT  = DEF_ADDR_FSTAT,
   parameter logic [15:0] ADDR_TX     = DEF_ADDR_TX,
   parameter logic [15:0] ADDR_RX     = DEF_ADDR_RX,
   parameter logic [31:0] CSR_ON      = DEF_CSR_ON,
   parameter int          TXFULL_BIT  = DEF_TXFULL_BIT,
   parameter int          RXEMPTY_BIT = DEF_RXEMPTY_BIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic [13:0] cfg_div,
   output logic        running,
   output logic        err,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [7:0]  tx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [7:0]  rx_data,
   output logic        apbm_psel,
   output logic        apbm_penable,
   output logic        apbm_pwrite,
   output logic [15:0] apbm_paddr,
   output logic [31:0] apbm_pwdata,
   input  logic [31:0] apbm_prdata,
   input  logic        apbm_pready,
   input  logic        apbm_pslverr
);
   state_t      st, st_nxt;
   logic        req, write, done, slverr, stop_pend, run_st, eff_stop, tx_ok;
   logic [15:0] addr;
   logic [31:0] wdata, rdata;
   logic        unused_bits;
`ifdef UART_APB_CTRL_RX_EN
   logic        rx_ok, prefer_rx;
`endif
   assign unused_bits = ^{rdata, rx_ready};
   assign tx_ready    = st == TXW && done;
   always_comb begin
      st_nxt   = st;
      run_st   = !(st inside {IDLE, WDIV, WCSR, STOP});
      eff_stop = stop_pend || (cfg_stop && run_st);
      tx_ok    = tx_valid && !rdata[TXFULL_BIT];
`ifdef UART_APB_CTRL_RX_EN
      rx_ok    = !rdata[RXEMPTY_BIT] && !rx_valid;
`endif
      case (st)
         IDLE: st_nxt = cfg_start ? WDIV : IDLE;
         WDIV: st_nxt = done ? WCSR : WDIV;
         WCSR: st_nxt = done ? POLL : WCSR;
`ifdef UART_APB_CTRL_RX_EN
         POLL: st_nxt = !done ? POLL : rx_ok && (prefer_rx || !tx_ok) ? RXR : tx_ok ? TXW : eff_stop ? STOP : POLL;
         RXR:  st_nxt = !done ? RXR : eff_stop ? STOP : POLL;
`else
         POLL: st_nxt = !done ? POLL : tx_ok ? TXW : eff_stop ? STOP : POLL;
`endif
         TXW:  st_nxt = !done ? TXW : eff_stop ? STOP : POLL;
         STOP: st_nxt = done ? IDLE : STOP;
         default: st_nxt = IDLE;
      endcase
      // Requests follow the next state so a new SETUP starts right after each completion;
      // the engine ignores req while a transfer is still in flight.
      req   = st_nxt != IDLE;
      write = st_nxt inside {WDIV, WCSR, TXW, STOP};
      addr  = st_nxt == WDIV ? ADDR_DIV : st_nxt inside {WCSR, STOP} ? ADDR_CSR : st_nxt == TXW ? ADDR_TX : ADDR_FSTAT;
`ifdef UART_APB_CTRL_RX_EN
      if (st_nxt == RXR) addr = ADDR_RX;
`endif
      wdata = st_nxt == WDIV ? {18'h0, cfg_div} : st_nxt == WCSR ? CSR_ON : st_nxt == TXW ? {24'h0, tx_data} : 32'h0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         stop_pend <= 1'b0;
         running   <= 1'b0;
         err       <= 1'b0;
      end else begin
         st        <= st_nxt;
         stop_pend <= st == IDLE ? 1'b0 : stop_pend || (cfg_stop && run_st);
         running   <= st == WCSR && done ? 1'b1 : st == STOP && done ? 1'b0 : running;
         err       <= st == IDLE && cfg_start ? 1'b0 : err || slverr;
      end
   end
`ifdef UART_APB_CTRL_RX_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid  <= 1'b0;
         rx_data   <= 8'h0;
         prefer_rx <= 1'b1;
      end else begin
         if (st == RXR && done) begin
            rx_valid <= 1'b1;
            rx_data  <= rdata[7:0];
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
         prefer_rx <= st == IDLE && cfg_start ? 1'b1 : st == POLL && st_nxt == TXW ? 1'b1 : st == POLL && st_nxt == RXR ? 1'b0 : prefer_rx;
      end
   end
`else
   assign rx_valid = 1'b0;
   assign rx_data  = 8'h0;
`endif
   uart_apb_ctrl_xfer u_xfer (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .addr         (addr),
      .write        (write),
      .wdata        (wdata),
      .done         (done),
      .rdata        (rdata),
      .slverr       (slverr),
      .apbm_psel    (apbm_psel),
      .apbm_penable (apbm_penable),
      .apbm_pwrite  (apbm_pwrite),
      .apbm_paddr   (apbm_paddr),
      .apbm_pwdata  (apbm_pwdata),
      .apbm_prdata  (apbm_prdata),
      .apbm_pready  (apbm_pready),
      .apbm_pslverr (apbm_pslverr)
   );
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb_uart_apb_ctrl: scoreboard bench for uart_apb_ctrl with a behavioural uart_mini APB slave.
module tb_uart_apb_ctrl;
   import uart_apb_ctrl_pkg::*;
   typedef struct packed {logic [15:0] addr; logic wr; logic [31:0] data;} xfer_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cfg_start = 1'b0, cfg_stop = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0;
   logic [13:0] cfg_div = 14'h0;
   logic [7:0]  tx_data = 8'h0, rx_base = 8'h3c;
   logic        running, err, tx_ready, rx_valid;
   logic [7:0]  rx_data;
   logic        apbm_psel, apbm_penable, apbm_pwrite, apbm_pready, apbm_pslverr;
   logic [15:0] apbm_paddr;
   logic [31:0] apbm_pwdata, apbm_prdata, fstat;
   logic        rx_empty = 1'b1, hold = 1'b0;
   int          fstat_cnt = 0, full_until = 0, tx_cnt = 0, rx_cnt = 0, err_idx = -1, cyc = 0;
   int          checks = 0, errors = 0;
   xfer_t       exp_q[$], obs_q[$];
   logic [7:0]  tx_acc[$], rx_acc[$], exp_rx[$];
   int          tx_cyc[$];

   always #5 clk = ~clk;

   uart_apb_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_div(cfg_div),
      .running(running), .err(err), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .apbm_psel(apbm_psel), .apbm_penable(apbm_penable), .apbm_pwrite(apbm_pwrite),
      .apbm_paddr(apbm_paddr), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
      .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
   );

   // uart_mini slave model: FSTAT reports TX full until full_until polls have been served
   assign fstat        = {6'h0, rx_empty, 16'h0, fstat_cnt < full_until, 8'h0};
   assign apbm_pready  = apbm_penable && !hold;
   assign apbm_prdata  = apbm_paddr == DEF_ADDR_FSTAT ? fstat : apbm_paddr == DEF_ADDR_RX ? {24'h0, rx_base + 8'(rx_cnt)} : 32'h0;
   assign apbm_pslverr = apbm_psel && apbm_penable && apbm_paddr == DEF_ADDR_TX && tx_cnt == err_idx;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (apbm_psel && apbm_penable && apbm_pready) begin
         if (apbm_paddr == DEF_ADDR_FSTAT) fstat_cnt <= fstat_cnt + 1;
         if (apbm_paddr == DEF_ADDR_TX) tx_cnt <= tx_cnt + 1;
         if (apbm_paddr == DEF_ADDR_RX) rx_cnt <= rx_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (apbm_psel && apbm_penable && apbm_pready && apbm_paddr != DEF_ADDR_FSTAT)
         obs_q.push_back('{apbm_paddr, apbm_pwrite, apbm_pwdata});
      if (tx_valid && tx_ready) begin
         tx_acc.push_back(tx_data);
         tx_cyc.push_back(cyc);
      end
      if (rx_valid && rx_ready) rx_acc.push_back(rx_data);
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (obs_q.size() >= n) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({apbm_psel, apbm_penable, apbm_pwrite} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 000", {apbm_psel, apbm_penable, apbm_pwrite});
      end
      checks++;
      if ({apbm_paddr, apbm_pwdata} !== 48'h0) begin
         errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", apbm_paddr, apbm_pwdata);
      end
      checks++;
      if ({running, err, tx_ready, rx_valid} !== 4'b0000) begin
         errors++; $display("FAIL reset_status: got %b want 0000", {running, err, tx_ready, rx_valid});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_start;
      bit ok;
      xfer_t e, o;
      cfg_div = 14'h0a4;
      cfg_start = 1'b1;
      exp_q.push_back('{DEF_ADDR_DIV, 1'b1, 32'h0000_00a4});
      exp_q.push_back('{DEF_ADDR_CSR, 1'b1, 32'h1});
      tick();
      cfg_start = 1'b0;
      wait_obs(2, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL start_timeout: got %0d writes want 2", obs_q.size()); end
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL start_running_early: got %b want 0", running); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
         checks++;
         if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
            errors++; $display("FAIL start_xfer: got %h/%b/%h want %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
         end
      end
      tick();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b want 1", running); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL start_err: got %b want 0", err); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int n = 0;
      xfer_t e, o;
      tx_data = 8'h55;
      tx_valid = 1'b1;
      exp_q.push_back('{DEF_ADDR_TX, 1'b1, 32'h55});
      exp_q.push_back('{DEF_ADDR_TX, 1'b1, 32'haa});
      for (int i = 0; i < 200 && n < 2; i++) begin
         tick();
         if (tx_ready) begin
            n++;
            tick();
            if (n == 1) tx_data = 8'haa;
            else tx_valid = 1'b0;
         end
      end
      tx_valid = 1'b0;
      wait_obs(2, ok);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
         checks++;
         if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
            errors++; $display("FAIL b2b_xfer: got %h/%b/%h want %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
         end
      end
      checks++;
      if (tx_acc.size() != 2 || tx_acc[0] !== 8'h55 || tx_acc[1] !== 8'haa) begin
         errors++; $display("FAIL b2b_handshakes: got %0d handshakes want 2 (55,aa)", tx_acc.size());
      end
      checks++;
      if (tx_cyc.size() < 2 || tx_cyc[1] - tx_cyc[0] != 4) begin
         errors++; $display("FAIL b2b_throughput: got %0d cycles want 4", tx_cyc.size() < 2 ? -1 : tx_cyc[1] - tx_cyc[0]);
      end
      tx_acc.delete();
      tx_cyc.delete();
   endtask

   task automatic test_txfull;
      bit ok;
      int start;
      xfer_t e, o;
      start = fstat_cnt;
      full_until = start + 3;
      tx_data = 8'h77;
      tx_valid = 1'b1;
      exp_q.push_back('{DEF_ADDR_TX, 1'b1, 32'h77});
      wait_obs(1, ok);
      checks++;
      if (!ok || fstat_cnt != start + 4) begin
         errors++; $display("FAIL txfull_polls: got %0d polls want 4", fstat_cnt - start);
      end
      checks++;
      if (tx_acc.size() != 1) begin errors++; $display("FAIL txfull_ready: got %0d handshakes want 1", tx_acc.size()); end
      tick();
      tx_valid = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
         checks++;
         if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
            errors++; $display("FAIL txfull_xfer: got %h/%b/%h want %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
         end
      end
      tx_acc.delete();
      tx_cyc.delete();
   endtask

   task automatic test_rx_hold;
      bit ok;
      xfer_t o;
      rx_ready = 1'b0;
      rx_base = 8'h3c - 8'(rx_cnt);
      rx_empty = 1'b0;
      exp_q.push_back('{DEF_ADDR_RX, 1'b0, 32'h0});
      wait_obs(1, ok);
      o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
      void'(exp_q.pop_front());
      checks++;
      if (o.addr !== DEF_ADDR_RX || o.wr !== 1'b0) begin
         errors++; $display("FAIL rx_read: got %h/%b want %h/0", o.addr, o.wr, DEF_ADDR_RX);
      end
      tick();
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h3c) begin
         errors++; $display("FAIL rx_data: got %b/%h want 1/3c", rx_valid, rx_data);
      end
      repeat (20) tick();
      checks++;
      if (obs_q.size() != 0 || rx_valid !== 1'b1) begin
         errors++; $display("FAIL rx_hold: got %0d extra reads valid %b want 0 reads valid 1", obs_q.size(), rx_valid);
      end
      rx_ready = 1'b1;
      rx_empty = 1'b1;
      tick();
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0 || rx_acc.size() != 1) begin
         errors++; $display("FAIL rx_consume: got valid %b handshakes %0d want 0/1", rx_valid, rx_acc.size());
      end
      rx_acc.delete();
   endtask

   task automatic test_stop_restart;
      bit ok;
      xfer_t e, o;
      cfg_stop = 1'b1;
      exp_q.push_back('{DEF_ADDR_CSR, 1'b1, 32'h0});
      tick();
      cfg_stop = 1'b0;
      wait_obs(1, ok);
      checks++;
      if (!ok || running !== 1'b1) begin errors++; $display("FAIL stop_running_early: got %b want 1", running); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
         checks++;
         if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
            errors++; $display("FAIL stop_xfer: got %h/%b/%h want %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
         end
      end
      tick();
      checks++;
      if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", running); end
      repeat (10) tick();
      checks++;
      if (apbm_psel !== 1'b0 || obs_q.size() != 0) begin
         errors++; $display("FAIL stop_idle: got psel %b writes %0d want 0/0", apbm_psel, obs_q.size());
      end
      cfg_div = 14'h3fff;
      cfg_start = 1'b1;
      cfg_stop = 1'b1;
      exp_q.push_back('{DEF_ADDR_DIV, 1'b1, 32'h0000_3fff});
      exp_q.push_back('{DEF_ADDR_CSR, 1'b1, 32'h1});
      tick();
      cfg_start = 1'b0;
      cfg_stop = 1'b0;
      wait_obs(2, ok);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
         checks++;
         if (o.addr !== e.addr || o.wr !== e.wr || o.data !== e.data) begin
            errors++; $display("FAIL restart_xfer: got %h/%b/%h want %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
         end
      end
      repeat (20) tick();
      checks++;
      if (obs_q.size() != 0 || running !== 1'b1) begin
         errors++; $display("FAIL restart_stop_dropped: got writes %0d running %b want 0/1", obs_q.size(), running);
      end
   endtask

   task automatic test_alternate;
      bit ok, upd = 1'b0;
      xfer_t e, o;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL alt_err_clear: got %b want 0", err); end
      rx_base = 8'h40;
      exp_rx.push_back(8'h40 + 8'(rx_cnt));
      exp_rx.push_back(8'h41 + 8'(rx_cnt));
      err_idx = tx_cnt;
      exp_q.push_back('{DEF_ADDR_RX, 1'b0, 32'h0});
      exp_q.push_back('{DEF_ADDR_TX, 1'b1, 32'hd0});
      exp_q.push_back('{DEF_ADDR_RX, 1'b0, 32'h0});
      exp_q.push_back('{DEF_ADDR_TX, 1'b1, 32'hd1});
      rx_ready = 1'b1;
      rx_empty = 1'b0;
      tx_data = 8'hd0;
      tx_valid = 1'b1;
      for (int i = 0; i < 300 && obs_q.size() < 4; i++) begin
         tick();
         if (upd) begin tx_data = tx_data + 8'h1; upd = 1'b0; end
         if (tx_ready) upd = 1'b1;
      end
      tick();
      tx_valid = 1'b0;
      rx_empty = 1'b1;
      repeat (4) tick();
      rx_ready = 1'b0;
      err_idx = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.size() > 0 ? obs_q.pop_front() : '1;
         checks++;
         if (o.addr !== e.addr || o.wr !== e.wr || (e.wr && o.data !== e.data)) begin
            errors++; $display("FAIL alt_order: got %h/%b/%h want %h/%b/%h", o.addr, o.wr, o.data, e.addr, e.wr, e.data);
         end
      end
      while (exp_rx.size() > 0) begin
         logic [7:0] x, y;
         x = exp_rx.pop_front();
         y = rx_acc.size() > 0 ? rx_acc.pop_front() : 8'hxx;
         checks++;
         if (y !== x) begin errors++; $display("FAIL alt_rx_byte: got %h want %h", y, x); end
      end
      checks++;
      if (tx_acc.size() != 2 || tx_acc[0] !== 8'hd0 || tx_acc[1] !== 8'hd1) begin
         errors++; $display("FAIL alt_tx_consumed: got %0d handshakes want 2 (d0,d1)", tx_acc.size());
      end
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL alt_err_sticky: got %b want 1", err); end
      tx_acc.delete();
      tx_cyc.delete();
   endtask

   task automatic test_reset_mid;
      bit ok = 1'b0;
      hold = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         ok = apbm_psel && apbm_penable;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_access: got no ACCESS want ACCESS"); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (apbm_psel !== 1'b0 || apbm_penable !== 1'b0) begin
         errors++; $display("FAIL rstmid_psel: got %b/%b want 0/0", apbm_psel, apbm_penable);
      end
      hold = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      checks++;
      if (apbm_psel !== 1'b0 || obs_q.size() != 0 || running !== 1'b0) begin
         errors++; $display("FAIL rstmid_idle: got psel %b writes %0d running %b want 0/0/0", apbm_psel, obs_q.size(), running);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_back_to_back();
      test_txfull();
`ifdef UART_APB_CTRL_RX_EN
      test_rx_hold();
`endif
      test_stop_restart();
`ifdef UART_APB_CTRL_RX_EN
      test_alternate();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
